// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the mm:ss countdown timer: state encoding and default field geometry.
package countdown_timer_pkg;

    localparam int DEF_X = 6;
    localparam int DEF_N = 60;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/countdown_timer_down_counter_nbits.sv
// Mod-n down counter; wraps from 0 to n-1 and flags the wrap as a combinational borrow.
module down_counter_nbits
    import countdown_timer_pkg::*;
#(
    parameter int W = DEF_X,
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         borrow
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = (count_q == '0) ? W'(N - 1) : count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign borrow = en && (count_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with load/start/pause/clear control and expiry flagging.
//
//   state  | meaning
//   IDLE   | preset held, waiting for start
//   RUN    | decrementing on each en tick
//   PAUSE  | count frozen, start resumes
//   DONE   | reached 00:00, held until clear/load
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int x = DEF_X,
    parameter int n = DEF_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [x-1:0] load_sec,
    input  logic [x-1:0] load_min,
    input  logic         start,
    input  logic         pause,
    input  logic         clear,
    output logic [x-1:0] sec,
    output logic [x-1:0] min,
    output logic         running,
    output logic         expired,
    output logic         done
);

    state_e       state_q, state_d;
    logic         running_q, expired_q, done_q, done_d;
    logic         cnt_load, tick;
    logic [x-1:0] sec_load_val, min_load_val;
    logic [x-1:0] sec_cnt, min_cnt;
    logic         sec_borrow, min_borrow;
    logic         is_zero, is_one;

    assign is_zero = (min_cnt == '0) && (sec_cnt == '0);
    assign is_one  = (min_cnt == '0) && (sec_cnt == x'(1));

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        tick         = 1'b0;
        sec_load_val = '0;
        min_load_val = '0;
        if (clear) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
        end else if (load && (state_q != ST_RUN)) begin
            state_d      = ST_IDLE;
            cnt_load     = 1'b1;
            sec_load_val = (32'(load_sec) >= n) ? x'(n - 1) : load_sec;
            min_load_val = (32'(load_min) >= n) ? x'(n - 1) : load_min;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
            // A start on 00:00 is swallowed, including any en that came with it.
            if (!is_zero) begin
                state_d = ST_RUN;
            end
        end else if (pause && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (en && (state_q == ST_RUN)) begin
            tick = 1'b1;
            if (is_one) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_DONE);
            done_q    <= done_d;
        end
    end

    down_counter_nbits #(.W(x), .N(n)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .en       (tick),
        .load     (cnt_load),
        .load_val (sec_load_val),
        .count    (sec_cnt),
        .borrow   (sec_borrow)
    );

    // Minutes only move when seconds wrap through zero.
    down_counter_nbits #(.W(x), .N(n)) u_min (
        .clk      (clk),
        .reset    (reset),
        .en       (sec_borrow),
        .load     (cnt_load),
        .load_val (min_load_val),
        .count    (min_cnt),
        .borrow   (min_borrow)
    );

    logic unused_min_borrow;
    assign unused_min_borrow = min_borrow;

    assign sec     = sec_cnt;
    assign min     = min_cnt;
    assign running = running_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed expected values.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset, en, load, start, pause, clear;
    logic [5:0] load_sec, load_min;
    logic [5:0] sec, min;
    logic       running, expired, done;

    int vectors = 0;
    int miscompares = 0;

    countdown_timer #(.x(6), .n(60)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_sec (load_sec),
        .load_min (load_min),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .sec      (sec),
        .min      (min),
        .running  (running),
        .expired  (expired),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; load = 0; start = 0; pause = 0; clear = 0;
        load_sec = '0; load_min = '0;
    endtask

    task automatic chk(input string tag, input logic [5:0] e_min, input logic [5:0] e_sec,
                       input logic e_run, input logic e_exp, input logic e_done);
        logic [14:0] obs, expv;
        obs  = {min, sec, running, expired, done};
        expv = {e_min, e_sec, e_run, e_exp, e_done};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed min=%0d sec=%0d run=%0b exp=%0b done=%0b, expected min=%0d sec=%0d run=%0b exp=%0b done=%0b",
                   tag, min, sec, running, expired, done, e_min, e_sec, e_run, e_exp, e_done);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        en = 1; load = 1; start = 1; load_sec = 6'($urandom); load_min = 6'($urandom);
        step();
        en = 1'($urandom); load = 1'($urandom); start = 1'($urandom);
        pause = 1'($urandom); clear = 1'($urandom);
        step();
        chk("reset", 0, 0, 0, 0, 0);
        reset = 0;
        idle_inputs();

        // Load 01:05 and count through the minute borrow
        load = 1; load_min = 1; load_sec = 5; step(); idle_inputs();
        chk("load_0105", 1, 5, 0, 0, 0);
        start = 1; step(); idle_inputs();
        chk("start_0105", 1, 5, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            en = 1; step(); idle_inputs();
            chk($sformatf("dec_%0d", i), 1, 6'(4 - i), 1, 0, 0);
        end
        en = 1; step(); idle_inputs();
        chk("borrow_0059", 0, 59, 1, 0, 0);
        clear = 1; step(); idle_inputs();
        chk("clear_run", 0, 0, 0, 0, 0);

        // Expiry from 00:02
        load = 1; load_sec = 2; step(); idle_inputs();
        start = 1; step(); idle_inputs();
        en = 1; step(); idle_inputs();
        chk("exp_0001", 0, 1, 1, 0, 0);
        en = 1; step(); idle_inputs();
        chk("exp_0000", 0, 0, 0, 1, 1);
        step();
        chk("done_one_cycle", 0, 0, 0, 1, 0);
        en = 1; start = 1; step(); idle_inputs();
        chk("done_hold", 0, 0, 0, 1, 0);

        // Pause with en, resume with en
        load = 1; load_sec = 10; step(); idle_inputs();
        chk("load_from_done", 0, 10, 0, 0, 0);
        start = 1; step(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            en = 1; step(); idle_inputs();
        end
        chk("run_0007", 0, 7, 1, 0, 0);
        pause = 1; en = 1; step(); idle_inputs();
        chk("pause_en", 0, 7, 0, 0, 0);
        en = 1; step(); idle_inputs();
        chk("paused_en", 0, 7, 0, 0, 0);
        start = 1; en = 1; step(); idle_inputs();
        chk("resume_en", 0, 7, 1, 0, 0);
        en = 1; step(); idle_inputs();
        chk("resume_dec", 0, 6, 1, 0, 0);
        load = 1; load_min = 0; load_sec = 30; step(); idle_inputs();
        chk("load_in_run", 0, 6, 1, 0, 0);
        en = 1; pause = 0; start = 1; step(); idle_inputs();
        chk("start_in_run", 0, 5, 1, 0, 0);

        // Clamping
        clear = 1; step(); idle_inputs();
        load = 1; load_min = 63; load_sec = 62; step(); idle_inputs();
        chk("clamp_63_62", 59, 59, 0, 0, 0);
        load = 1; load_min = 60; load_sec = 59; step(); idle_inputs();
        chk("clamp_60_59", 59, 59, 0, 0, 0);
        load = 1; load_min = 0; load_sec = 60; step(); idle_inputs();
        chk("clamp_00_60", 0, 59, 0, 0, 0);
        clear = 1; step(); idle_inputs();
        start = 1; en = 1; step(); idle_inputs();
        chk("start_on_zero", 0, 0, 0, 0, 0);

        // Clear beats load while running
        load = 1; load_min = 2; load_sec = 30; step(); idle_inputs();
        start = 1; step(); idle_inputs();
        chk("run_0230", 2, 30, 1, 0, 0);
        clear = 1; load = 1; load_min = 5; load_sec = 5; step(); idle_inputs();
        chk("clear_over_load", 0, 0, 0, 0, 0);

        // Borrow from 01:00 then reset mid-count
        load = 1; load_min = 1; load_sec = 0; step(); idle_inputs();
        start = 1; step(); idle_inputs();
        chk("run_0100", 1, 0, 1, 0, 0);
        reset = 1; en = 1; start = 1; load = 1; load_sec = 9; load_min = 9; step();
        reset = 0; idle_inputs();
        chk("reset_mid_run", 0, 0, 0, 0, 0);
        load = 1; load_min = 1; load_sec = 0; step(); idle_inputs();
        start = 1; step(); idle_inputs();
        en = 1; step();
        chk("held_en_1", 0, 59, 1, 0, 0);
        step(); idle_inputs();
        chk("held_en_2", 0, 58, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
